// File: rtl/axi_sram_bridge_mp_if.sv
// AXI3 master-side bus bundle for axi_sram_bridge_mp.
// Latency: none, wires only.
// Backpressure: none of its own; plain valid/ready channels between master and slave.
// Ports: master modport drives AR/AW/W valids and payload plus rready/bready.
//        slave modport is the mirror image.
interface axi_sram_bridge_mp_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // read address
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [3:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [1:0]          arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  // read data
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;
  // write address
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [1:0]          awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  // write data
  logic [ID_W-1:0]     wid;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  // write response
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_sram_bridge_mp.sv
// Multi-port SRAM-like to AXI3 master bridge, one AXI transaction outstanding.
// Latency: addr_ok combinational in IDLE; AR/AW+W valid the next cycle; data_ok same cycle as rvalid/bvalid.
// Backpressure: requests wait (addr_ok low) while a transaction is in flight; AXI valids hold until ready.
// Ports: aclk/reset (async, active-high); p_* per-port SRAM-like request/response vectors;
//        m_axi is the AXI3 master bundle (axi_sram_bridge_mp_if.master).
// Config: define BRIDGE_RR_EN for round-robin arbitration; default is fixed lowest-index priority.
module axi_sram_bridge_mp #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4
) (
  input  logic                              aclk,
  input  logic                              reset,
  input  logic [NUM_PORTS-1:0]              p_req,
  input  logic [NUM_PORTS-1:0]              p_wr,
  input  logic [3*NUM_PORTS-1:0]            p_size,
  input  logic [4*NUM_PORTS-1:0]            p_len,
  input  logic [ADDR_W*NUM_PORTS-1:0]       p_addr,
  input  logic [DATA_W*NUM_PORTS-1:0]       p_wdata,
  input  logic [(DATA_W/8)*NUM_PORTS-1:0]   p_wstrb,
  output logic [NUM_PORTS-1:0]              p_addr_ok,
  output logic [NUM_PORTS-1:0]              p_data_ok,
  output logic [NUM_PORTS-1:0]              p_rlast,
  output logic [DATA_W-1:0]                 p_rdata,
  axi_sram_bridge_mp_if.master              m_axi
);
  localparam int GW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B} state_t;

  state_t              state_q;
  logic [GW-1:0]       g_q;
  logic [2:0]          size_q;
  logic [3:0]          len_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                arvalid_q, awvalid_q, wvalid_q, rready_q, bready_q;

  // Per-port views of the flattened request buses.
  logic [2:0]          size_a  [NUM_PORTS];
  logic [3:0]          len_a   [NUM_PORTS];
  logic [ADDR_W-1:0]   addr_a  [NUM_PORTS];
  logic [DATA_W-1:0]   wdata_a [NUM_PORTS];
  logic [STRB_W-1:0]   wstrb_a [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign size_a[i]  = p_size[3*i +: 3];
    assign len_a[i]   = p_len[4*i +: 4];
    assign addr_a[i]  = p_addr[ADDR_W*i +: ADDR_W];
    assign wdata_a[i] = p_wdata[DATA_W*i +: DATA_W];
    assign wstrb_a[i] = p_wstrb[STRB_W*i +: STRB_W];
  end

  logic          any_req;
  logic [GW-1:0] grant;
  assign any_req = |p_req;

`ifdef BRIDGE_RR_EN
  logic [GW-1:0] ptr_q;
  logic [GW-1:0] ptr_d;
  logic [GW-1:0] sel;
  logic          found;
  int            idx;

  // Search starts at the pointer and wraps, so the first requester at or after it wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (int'(ptr_q) + k) % NUM_PORTS;
      sel = GW'(idx);
      if (!found && p_req[sel]) begin
        grant = sel;
        found = 1'b1;
      end
    end
  end

  assign ptr_d = (grant == GW'(NUM_PORTS - 1)) ? '0 : grant + GW'(1);
`else
  // Lowest index wins: scan downward so the last hit is the smallest requester.
  always_comb begin
    grant = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (p_req[GW'(k)]) grant = GW'(k);
    end
  end
`endif

  // addr_ok depends only on request and state; reset forces it low even while IDLE.
  assign p_addr_ok = (state_q == IDLE && any_req && !reset) ? (NUM_PORTS'(1) << grant) : '0;

  // Responses are steered combinationally to the latched grant.
  logic r_fire, b_fire;
  assign r_fire    = rready_q & m_axi.rvalid;
  assign b_fire    = bready_q & m_axi.bvalid;
  assign p_data_ok = (r_fire | b_fire) ? (NUM_PORTS'(1) << g_q) : '0;
  assign p_rlast   = (r_fire & m_axi.rlast) ? (NUM_PORTS'(1) << g_q) : '0;
  assign p_rdata   = r_fire ? m_axi.rdata : '0;

  // AXI master drive
  assign m_axi.arid    = ID_W'(g_q);
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = len_q;
  assign m_axi.arsize  = size_q;
  assign m_axi.arburst = 2'b01;
  assign m_axi.arlock  = 2'b00;
  assign m_axi.arcache = 4'b0000;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;
  assign m_axi.awid    = ID_W'(g_q);
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = 4'd0;
  assign m_axi.awsize  = size_q;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awlock  = 2'b00;
  assign m_axi.awcache = 4'b0000;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wid     = ID_W'(g_q);
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wlast   = wvalid_q;  // every write is one beat, so the beat is always last
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;

  // Response IDs and codes are not needed: only one transaction is ever outstanding.
  logic unused_resp;
  assign unused_resp = ^{m_axi.rid, m_axi.rresp, m_axi.bid, m_axi.bresp};

  // A channel counts as done if it already handshook or handshakes this cycle.
  logic aw_fin, w_fin;
  assign aw_fin = ~awvalid_q | m_axi.awready;
  assign w_fin  = ~wvalid_q  | m_axi.wready;

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      g_q       <= '0;
      size_q    <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      rready_q  <= 1'b0;
      bready_q  <= 1'b0;
`ifdef BRIDGE_RR_EN
      ptr_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            g_q     <= grant;
            size_q  <= size_a[grant];
            len_q   <= len_a[grant];
            addr_q  <= addr_a[grant];
            wdata_q <= wdata_a[grant];
            wstrb_q <= wstrb_a[grant];
`ifdef BRIDGE_RR_EN
            ptr_q   <= ptr_d;
`endif
            if (p_wr[grant]) begin
              state_q   <= AW_W;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= AR;
              arvalid_q <= 1'b1;
            end
          end
        end
        AR: begin
          if (m_axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= R;
          end
        end
        R: begin
          if (m_axi.rvalid && m_axi.rlast) begin
            rready_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        AW_W: begin
          if (m_axi.awready) awvalid_q <= 1'b0;
          if (m_axi.wready)  wvalid_q  <= 1'b0;
          if (aw_fin && w_fin) begin
            bready_q <= 1'b1;
            state_q  <= B;
          end
        end
        B: begin
          if (m_axi.bvalid) begin
            bready_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_sram_bridge_mp.sv
// Directed bench for axi_sram_bridge_mp with a response scoreboard.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge or after that 1ns.
module tb_axi_sram_bridge_mp;
  localparam int NP = 2;

  logic          aclk = 1'b0;
  logic          reset;
  logic [NP-1:0] p_req, p_wr;
  logic [3*NP-1:0]  p_size;
  logic [4*NP-1:0]  p_len;
  logic [32*NP-1:0] p_addr, p_wdata;
  logic [4*NP-1:0]  p_wstrb;
  logic [NP-1:0] p_addr_ok, p_data_ok, p_rlast;
  logic [31:0]   p_rdata;

  axi_sram_bridge_mp_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) axi ();

  axi_sram_bridge_mp #(.NUM_PORTS(NP), .ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .aclk(aclk), .reset(reset),
    .p_req(p_req), .p_wr(p_wr), .p_size(p_size), .p_len(p_len), .p_addr(p_addr),
    .p_wdata(p_wdata), .p_wstrb(p_wstrb),
    .p_addr_ok(p_addr_ok), .p_data_ok(p_data_ok), .p_rlast(p_rlast), .p_rdata(p_rdata),
    .m_axi(axi.master)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        last;
    logic        wr;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;
  int pops     = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every data_ok must match the oldest expected response.
  always @(negedge aclk) begin
    if (reset === 1'b0 && p_data_ok !== '0) begin
      if (q.size() == 0) begin
        chk("unexpected_data_ok", 64'(p_data_ok), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        pops++;
        chk("data_ok_port", 64'(p_data_ok), 64'(1) << e.port);
        if (!e.wr) begin
          chk("rlast", 64'(p_rlast), e.last ? (64'(1) << e.port) : 64'd0);
          chk("rdata", 64'(p_rdata), 64'(e.data));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_port(input int p, input logic wr, input logic [3:0] len,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st);
    p_wr[p]           = wr;
    p_size[3*p +: 3]  = 3'd2;
    p_len[4*p +: 4]   = len;
    p_addr[32*p +: 32]  = addr;
    p_wdata[32*p +: 32] = wd;
    p_wstrb[4*p +: 4]   = st;
  endtask

  task automatic ar_accept(input int id, input logic [31:0] addr, input logic [3:0] len);
    int n;
    n = 0;
    while (axi.arvalid !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    chk("ar_seen", 64'(axi.arvalid), 64'd1);
    chk("ar_latency", 64'(n), 64'd0);
    chk("arid", 64'(axi.arid), 64'(id));
    chk("araddr", 64'(axi.araddr), 64'(addr));
    chk("arlen", 64'(axi.arlen), 64'(len));
    chk("arsize", 64'(axi.arsize), 64'd2);
    axi.arready = 1'b1;
    cyc();
    axi.arready = 1'b0;
    chk("ar_drop", 64'(axi.arvalid), 64'd0);
    chk("rready_on", 64'(axi.rready), 64'd1);
  endtask

  task automatic r_beat(input int port, input logic [31:0] d, input logic last, input int gap);
    repeat (gap) cyc();
    axi.rvalid = 1'b1;
    axi.rdata  = d;
    axi.rlast  = last;
    q.push_back('{port, d, last, 1'b0});
    cyc();
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    axi.rdata  = '0;
  endtask

  initial begin
    int exp_g[4];
    int n, g, p0;

    reset = 1'b1;
    p_req = '0; p_wr = '0; p_size = '0; p_len = '0;
    p_addr = '0; p_wdata = '0; p_wstrb = '0;
    axi.arready = 0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 0; axi.rvalid = 0;
    axi.awready = 0; axi.wready = 0; axi.bid = '0; axi.bresp = '0; axi.bvalid = 0;

    // ---- reset state, with a live request that must not be acknowledged
    repeat (2) @(negedge aclk);
    p_req = 2'b11;
    #1;
    chk("rst_addr_ok", 64'(p_addr_ok), 64'd0);
    chk("rst_data_ok", 64'(p_data_ok), 64'd0);
    chk("rst_rlast", 64'(p_rlast), 64'd0);
    chk("rst_rdata", 64'(p_rdata), 64'd0);
    chk("rst_arvalid", 64'(axi.arvalid), 64'd0);
    chk("rst_awvalid", 64'(axi.awvalid), 64'd0);
    chk("rst_wvalid", 64'(axi.wvalid), 64'd0);
    chk("rst_wlast", 64'(axi.wlast), 64'd0);
    chk("rst_rready", 64'(axi.rready), 64'd0);
    chk("rst_bready", 64'(axi.bready), 64'd0);
    chk("rst_arburst", 64'(axi.arburst), 64'd1);
    chk("rst_awburst", 64'(axi.awburst), 64'd1);
    p_req = '0;
    cyc();
    reset = 1'b0;

    // ---- single read, port 0
    set_port(0, 1'b0, 4'd0, 32'h1FC0_0000, 32'h0, 4'h0);
    p_req = 2'b01;
    @(negedge aclk);
    chk("rd1_addr_ok", 64'(p_addr_ok), 64'b01);
    cyc();
    p_req = '0;
    ar_accept(0, 32'h1FC0_0000, 4'd0);
    r_beat(0, 32'hDEAD_BEEF, 1'b1, 0);
    @(negedge aclk);
    chk("rd1_drain", 64'(q.size()), 64'd0);
    chk("rd1_idle", 64'(axi.rready), 64'd0);

    // ---- burst refill, port 1, 8 beats with gaps
    cyc();
    set_port(1, 1'b0, 4'd7, 32'h8000_1000, 32'h0, 4'h0);
    p_req = 2'b10;
    @(negedge aclk);
    chk("burst_addr_ok", 64'(p_addr_ok), 64'b10);
    cyc();
    p_req = '0;
    p0 = pops;
    ar_accept(1, 32'h8000_1000, 4'd7);
    for (int i = 0; i < 8; i++) r_beat(1, 32'(i), (i == 7), i % 3);
    @(negedge aclk);
    chk("burst_drain", 64'(q.size()), 64'd0);
    chk("burst_beats", 64'(pops - p0), 64'd8);
    chk("burst_idle", 64'(axi.rready), 64'd0);

    // ---- write with W accepted 3 cycles before AW
    cyc();
    set_port(0, 1'b1, 4'd5, 32'h0000_0040, 32'h1234_5678, 4'b0011);
    p_req = 2'b01;
    @(negedge aclk);
    chk("wr_addr_ok", 64'(p_addr_ok), 64'b01);
    cyc();
    p_req = '0;
    chk("wr_awvalid", 64'(axi.awvalid), 64'd1);
    chk("wr_wvalid", 64'(axi.wvalid), 64'd1);
    chk("wr_awlen", 64'(axi.awlen), 64'd0);
    chk("wr_wlast", 64'(axi.wlast), 64'd1);
    chk("wr_awaddr", 64'(axi.awaddr), 64'h40);
    chk("wr_wdata", 64'(axi.wdata), 64'h1234_5678);
    chk("wr_wstrb", 64'(axi.wstrb), 64'b0011);
    chk("wr_awid", 64'(axi.awid), 64'd0);
    chk("wr_wid", 64'(axi.wid), 64'd0);
    axi.wready = 1'b1;
    cyc();
    axi.wready = 1'b0;
    chk("wr_wvalid_drop", 64'(axi.wvalid), 64'd0);
    chk("wr_awvalid_hold", 64'(axi.awvalid), 64'd1);
    cyc();
    cyc();
    chk("wr_awvalid_hold2", 64'(axi.awvalid), 64'd1);
    chk("wr_no_bready", 64'(axi.bready), 64'd0);
    axi.awready = 1'b1;
    cyc();
    axi.awready = 1'b0;
    chk("wr_awvalid_drop", 64'(axi.awvalid), 64'd0);
    chk("wr_bready", 64'(axi.bready), 64'd1);
    cyc();
    axi.bvalid = 1'b1;
    q.push_back('{0, 32'h0, 1'b0, 1'b1});
    cyc();
    axi.bvalid = 1'b0;
    @(negedge aclk);
    chk("wr_drain", 64'(q.size()), 64'd0);
    chk("wr_bready_off", 64'(axi.bready), 64'd0);

    // ---- write with AW and W accepted in the same cycle, port 1
    cyc();
    set_port(1, 1'b1, 4'd0, 32'h0000_0080, 32'hCAFE_F00D, 4'b1111);
    p_req = 2'b10;
    cyc();
    p_req = '0;
    p_wr  = '0;
    chk("wr2_awid", 64'(axi.awid), 64'd1);
    axi.awready = 1'b1;
    axi.wready  = 1'b1;
    cyc();
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    chk("wr2_direct_b", 64'(axi.bready), 64'd1);
    axi.bvalid = 1'b1;
    q.push_back('{1, 32'h0, 1'b0, 1'b1});
    cyc();
    axi.bvalid = 1'b0;
    @(negedge aclk);
    chk("wr2_drain", 64'(q.size()), 64'd0);

    // ---- contention: both ports requesting for 4 transactions
`ifdef BRIDGE_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    cyc();
    set_port(0, 1'b0, 4'd0, 32'h0000_0100, 32'h0, 4'h0);
    set_port(1, 1'b0, 4'd0, 32'h0000_0200, 32'h0, 4'h0);
    p_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      g = exp_g[i];
      n = 0;
      @(negedge aclk);
      while (p_addr_ok === '0 && n < 20) begin
        @(negedge aclk);
        n++;
      end
      chk("cont_grant", 64'(p_addr_ok), 64'(1) << g);
      chk("cont_b2b", 64'(n), 64'd0);
      cyc();
      ar_accept(g, (g == 1) ? 32'h200 : 32'h100, 4'd0);
      r_beat(g, 32'hA000 + 32'(i), 1'b1, 0);
    end
    p_req = '0;
    @(negedge aclk);
    chk("cont_drain", 64'(q.size()), 64'd0);

    // ---- reset during an 8-beat read after 3 beats
    cyc();
    set_port(0, 1'b0, 4'd7, 32'h0000_3000, 32'h0, 4'h0);
    p_req = 2'b01;
    cyc();
    p_req = '0;
    ar_accept(0, 32'h0000_3000, 4'd7);
    for (int i = 0; i < 3; i++) r_beat(0, 32'hB0 + 32'(i), 1'b0, 0);
    reset = 1'b1;
    set_port(1, 1'b0, 4'd0, 32'h0000_5000, 32'h0, 4'h0);
    p_req = 2'b10;
    @(negedge aclk);
    chk("mid_rst_rready", 64'(axi.rready), 64'd0);
    chk("mid_rst_arvalid", 64'(axi.arvalid), 64'd0);
    chk("mid_rst_addr_ok", 64'(p_addr_ok), 64'd0);
    chk("mid_rst_data_ok", 64'(p_data_ok), 64'd0);
    chk("mid_rst_rdata", 64'(p_rdata), 64'd0);
    chk("mid_rst_araddr", 64'(axi.araddr), 64'd0);
    chk("mid_rst_beats", 64'(q.size()), 64'd0);
    cyc();
    reset = 1'b0;
    @(negedge aclk);
    chk("post_rst_addr_ok", 64'(p_addr_ok), 64'b10);
    cyc();
    p_req = '0;
    ar_accept(1, 32'h0000_5000, 4'd0);
    r_beat(1, 32'h0000_C0DE, 1'b1, 0);
    @(negedge aclk);
    chk("post_rst_drain", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
